pwm_multi: RTL
==============

Name: pwm_multi

Overview:
Multi-channel PWM generator; next generation of the single-channel pwm core behind the tt_um_* wrapper.
- One shared period counter drives CH compare channels.
- Adds a programmable period, edge-aligned and center-aligned modes, and shadowed (glitch-free) register updates.
- Each channel drives a complementary high/low output pair with programmable dead time, for half-bridge drive from uo_out.

Parameters:
CH, 2, number of PWM channels (1..8)
W, 7, counter/period/duty width in bits
DT_W, 4, dead-time field width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset (wrapper drives ~rst_n)
en  input  1  run enable; 0 = safe stop
mode  input  1  0 = edge-aligned, 1 = center-aligned
period  input  W  counter top value
duty  input  CH*W  per-channel compare value; channel i = duty[i*W +: W]
dt  input  DT_W  dead time in clk cycles, shared by all channels
pwm_h  output  CH  high-side outputs
pwm_l  output  CH  low-side (complementary) outputs
tick  output  1  one-cycle pulse on period wrap

Behaviour:
- Reset (async) values:
  - cnt=0, dir=up, en_q=0.
  - Shadow registers: period_sh = all ones, duty_sh = 0, mode_sh = 0.
  - raw_q = 0, dtc = 0 for every channel.
  - Outputs: pwm_h = 0, pwm_l = 0, tick = 0.
- en_q is en registered. While en_q = 0:
  - cnt held at 0, dir = up.
  - Shadows reload every cycle.
  - raw_q and dtc cleared.
  - pwm_h = pwm_l = 0 and tick = 0.
- Wrap condition, evaluated on shadow values:
  - Edge mode: wrap when cnt == period_sh; cnt then goes to 0.
  - Center mode: cnt counts 0,1..P,P-1..1,0,...; dir flips to down at cnt == P. Wrap is the cycle with dir = down and cnt == 1.
  - period_sh == 0: cnt stays 0 and every cycle is a wrap (both modes).
- On a wrap cycle (en_q = 1):
  - tick = 1 (registered, asserts the cycle after the wrap).
  - period, duty and mode load into the shadows; dir resets to up.
  - Inputs changed mid-cycle never affect the current period.
- Compare, per channel i: raw_q[i] <= (cnt < duty_sh[i]), unsigned W-bit compare.
  - duty = 0 gives constant low.
  - duty > period_sh gives constant high.
  - raw_q lags cnt by exactly 1 cycle.
  - Period length: edge mode P+1 cycles; center mode 2P cycles (high time 2*duty-1 when 0 < duty <= P).
- Dead time, per channel (pwm_deadtime sub-module):
  - When raw_q changes, dtc loads dt in that same edge; otherwise dtc decrements while nonzero.
  - pwm_h = en_q & raw_q & (dtc == 0).
  - pwm_l = en_q & ~raw_q & (dtc == 0).
  - pwm_h and pwm_l are never both 1.
  - dt = 0: outputs are an exact complementary copy of raw_q.
  - A raw toggle during dead time reloads dtc; a pulse shorter than or equal to dt never appears on either output.
- Reset mid-operation: all outputs low immediately (async); the counter restarts from 0 with reset shadows.

Decomposition:
- Shared package pwm_pkg holds:
  - mode encodings MODE_EDGE = 1'b0, MODE_CENTER = 1'b1;
  - default widths W_DEF = 7, DT_W_DEF = 4;
  - reset period constant (all ones).
- One sub-module, pwm_deadtime: inputs clk, reset, en_q, raw, dt; outputs h, l. Instantiated CH times via generate.
- Counter, wrap logic, shadows and comparators stay in pwm_multi.

Test Plan:
1. Edge mode, period=99, duty0=32, dt=0 -> tick every 100 cycles; pwm_h[0] high 32 cycles, pwm_l[0] high 68; never both high.
2. Same as 1 with dt=4 -> pwm_h[0] high 28 cycles, pwm_l[0] high 64, two 4-cycle gaps per period with both low.
3. Change duty0 32->80 mid-period -> current period keeps 32-cycle high; the period after the next tick shows 80-cycle high; no partial pulse.
4. Center mode, period=10, duty0=4, dt=0 -> 20-cycle period; pwm_h[0] high 7 consecutive cycles centred on cnt=0; tick once per 20 cycles.
5. duty0=0 -> pwm_h[0]=0 constantly; duty1=127 with period=99 -> pwm_h[1]=1 constantly; dt=5 with duty=3 -> pwm_h stays 0.
6. Assert reset or drop en mid-period -> pwm_h = pwm_l = 0 (reset: same cycle; en: next cycle); after release the first tick comes period_sh+1 cycles later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

  localparam int W_DEF    = 7;
  localparam int DT_W_DEF = 4;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic [W_DEF-1:0] PERIOD_RST = {W_DEF{1'b1}};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: registers the raw compare result and
// blanks both complementary outputs for dt cycles after every raw edge.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_q,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  output logic            h,
  output logic            l
);

  logic            r_raw_q;
  logic [DT_W-1:0] r_dtc;
  logic            w_quiet;

  // raw register and dead-time counter; a toggle during dead time restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_raw_q <= 1'b0;
      r_dtc   <= {DT_W{1'b0}};
    end else if (!en_q) begin
      r_raw_q <= 1'b0;
      r_dtc   <= {DT_W{1'b0}};
    end else begin
      r_raw_q <= raw;
      if (raw != r_raw_q) begin
        r_dtc <= dt;
      end else if (r_dtc != {DT_W{1'b0}}) begin
        r_dtc <= r_dtc - {{(DT_W-1){1'b0}}, 1'b1};
      end else begin
        r_dtc <= r_dtc;
      end
    end
  end

  assign w_quiet = (r_dtc == {DT_W{1'b0}});
  assign h       = en_q &  r_raw_q & w_quiet;
  assign l       = en_q & ~r_raw_q & w_quiet;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter, shadowed
// period/duty/mode registers, per-channel compare and dead-time pairs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH   = 2,
  parameter int W    = W_DEF,
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            mode,
  input  logic [W-1:0]    period,
  input  logic [CH*W-1:0] duty,
  input  logic [DT_W-1:0] dt,
  output logic [CH-1:0]   pwm_h,
  output logic [CH-1:0]   pwm_l,
  output logic            tick
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic            r_en_q;
  logic [W-1:0]    r_cnt;
  dir_e            r_dir;
  logic [W-1:0]    r_period_sh;
  logic [CH*W-1:0] r_duty_sh;
  logic            r_mode_sh;
  logic            r_tick;

  logic [W-1:0]    w_cnt_nxt;
  dir_e            w_dir_nxt;
  logic            w_wrap;
  logic [CH-1:0]   w_cmp;

  // Wrap detection and counter/direction next state, all on shadow values
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    if (r_period_sh == ZERO) begin
      w_wrap = 1'b1;
    end else if (r_mode_sh == MODE_EDGE) begin
      w_wrap = (r_cnt == r_period_sh);
    end else begin
      w_wrap = (r_dir == DIR_DOWN) && (r_cnt == ONE);
    end
    case (r_dir)
      DIR_UP: begin
        w_cnt_nxt = r_cnt + ONE;
        if ((r_mode_sh == MODE_CENTER) && ((r_cnt + ONE) == r_period_sh)) begin
          w_dir_nxt = DIR_DOWN;
        end else begin
          w_dir_nxt = DIR_UP;
        end
      end
      DIR_DOWN: begin
        w_cnt_nxt = r_cnt - ONE;
        w_dir_nxt = DIR_DOWN;
      end
      default: begin
        w_cnt_nxt = ZERO;
        w_dir_nxt = DIR_UP;
      end
    endcase
  end

  // Counter, shadows and tick; shadows track inputs while stopped, else only on wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_q      <= 1'b0;
      r_cnt       <= ZERO;
      r_dir       <= DIR_UP;
      r_period_sh <= {W{1'b1}};
      r_duty_sh   <= {(CH*W){1'b0}};
      r_mode_sh   <= MODE_EDGE;
      r_tick      <= 1'b0;
    end else begin
      r_en_q <= en;
      if (!r_en_q || w_wrap) begin
        r_cnt       <= ZERO;
        r_dir       <= DIR_UP;
        r_period_sh <= period;
        r_duty_sh   <= duty;
        r_mode_sh   <= mode;
        r_tick      <= r_en_q;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_dir  <= w_dir_nxt;
        r_tick <= 1'b0;
      end
    end
  end

  assign tick = r_tick;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign w_cmp[g] = (r_cnt < r_duty_sh[g*W +: W]);

    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk   (clk),
      .reset (reset),
      .en_q  (r_en_q),
      .raw   (w_cmp[g]),
      .dt    (dt),
      .h     (pwm_h[g]),
      .l     (pwm_l[g])
    );
  end

endmodule
